// File: rtl/colpar_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : colpar_ctrl
//  Description : Sequencer for one theta pass over SLICES slices; optional
//                abort port pair enabled by macro COLPAR_CTRL_ABORT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module colpar_ctrl #(
    parameter int SLICES = 64,
    parameter int ELEMS  = 25,
    parameter int AW     = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
`ifdef COLPAR_CTRL_ABORT_EN
    input  logic          abort,
    output logic          aborted,
`endif
    output logic [AW-1:0] sliceAddr,
    output logic          sliceRead,
    output logic          sliceWrite,
    output logic          ldLineK,
    output logic          ldLinePK,
    output logic          copyKtoPK,
    output logic          colparIJrster,
    output logic          calcEn,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_LAST = 3'd1,
        RD_CUR  = 3'd2,
        INIT    = 3'd3,
        CALC    = 3'd4,
        WR      = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam logic [AW-1:0] c_LAST_SLICE = AW'(SLICES - 1);
    localparam logic [4:0]    c_LAST_ELEM  = 5'(ELEMS - 1);

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_k;
    logic [4:0]    r_e;
    logic          w_abortHit;

`ifdef COLPAR_CTRL_ABORT_EN
    logic r_aborted;

    assign w_abortHit = abort && (r_state != IDLE) && (r_state != DONE);

    always_ff @(posedge clk) begin
        if (rst) r_aborted <= 1'b0;
        else     r_aborted <= w_abortHit;
    end

    assign aborted = r_aborted && !rst;
`else
    assign w_abortHit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // k is cleared at the start of a pass and only advances on a completed write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k <= '0;
        end else if (r_state == RD_LAST) begin
            r_k <= '0;
        end else if (r_state == WR && r_k != c_LAST_SLICE && !w_abortHit) begin
            r_k <= r_k + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                  r_e <= '0;
        else if (r_state == INIT) r_e <= '0;
        else if (r_state == CALC) r_e <= r_e + 1'b1;
    end

    always_comb begin
        w_next        = r_state;
        sliceAddr     = '0;
        sliceRead     = 1'b0;
        sliceWrite    = 1'b0;
        ldLineK       = 1'b0;
        ldLinePK      = 1'b0;
        copyKtoPK     = 1'b0;
        colparIJrster = 1'b0;
        calcEn        = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;

        case (r_state)
            IDLE:    if (start) w_next = RD_LAST;
            RD_LAST: begin
                sliceAddr = c_LAST_SLICE;
                sliceRead = 1'b1;
                ldLinePK  = 1'b1;
                w_next    = RD_CUR;
            end
            RD_CUR: begin
                sliceAddr = r_k;
                sliceRead = 1'b1;
                ldLineK   = 1'b1;
                w_next    = INIT;
            end
            INIT: begin
                colparIJrster = 1'b1;
                w_next        = CALC;
            end
            CALC: begin
                calcEn = 1'b1;
                if (r_e == c_LAST_ELEM) w_next = WR;
            end
            WR: begin
                sliceAddr  = r_k;
                sliceWrite = !w_abortHit;
                copyKtoPK  = 1'b1;
                w_next     = (r_k == c_LAST_SLICE) ? DONE : RD_CUR;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase

        busy = (r_state != IDLE);

        if (w_abortHit) w_next = IDLE;

        // Outputs are held quiet for the whole reset cycle, whatever the state
        if (rst) begin
            sliceAddr     = '0;
            sliceRead     = 1'b0;
            sliceWrite    = 1'b0;
            ldLineK       = 1'b0;
            ldLinePK      = 1'b0;
            copyKtoPK     = 1'b0;
            colparIJrster = 1'b0;
            calcEn        = 1'b0;
            busy          = 1'b0;
            done          = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_colpar_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_colpar_ctrl
//  Description : Self-checking bench for colpar_ctrl (vector table + passes).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_colpar_ctrl;

    localparam int c_SLICES = 64;
    localparam int c_ELEMS  = 25;
    localparam int c_DONE_CYC = 2 + c_SLICES * (c_ELEMS + 3);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [5:0] sliceAddr;
    logic       sliceRead, sliceWrite, ldLineK, ldLinePK, copyKtoPK;
    logic       colparIJrster, calcEn, busy, done;
`ifdef COLPAR_CTRL_ABORT_EN
    logic       abort = 1'b0;
    logic       aborted;
`endif

    always #5 clk = ~clk;

    colpar_ctrl #(.SLICES(c_SLICES), .ELEMS(c_ELEMS), .AW(6)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
`ifdef COLPAR_CTRL_ABORT_EN
        .abort(abort),
        .aborted(aborted),
`endif
        .sliceAddr(sliceAddr),
        .sliceRead(sliceRead),
        .sliceWrite(sliceWrite),
        .ldLineK(ldLineK),
        .ldLinePK(ldLinePK),
        .copyKtoPK(copyKtoPK),
        .colparIJrster(colparIJrster),
        .calcEn(calcEn),
        .busy(busy),
        .done(done)
    );

    int nChecks = 0;
    int nErrors = 0;

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nErrors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // {busy, done, rd, wr, ldK, ldPK, copy, ijRst, calcEn, addr[5:0]}
    function automatic logic [14:0] mk(input logic b, input logic d, input logic rd,
                                       input logic wr, input logic lk, input logic lpk,
                                       input logic cp, input logic ij, input logic ce,
                                       input logic [5:0] a);
        return {b, d, rd, wr, lk, lpk, cp, ij, ce, a};
    endfunction

    typedef struct {
        logic        rst;
        logic        start;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[10];

    // Per-pass statistics collected by runPass
    int doneCycle, doneCount, wrCount, wrOrderErr, wrSpacingErr;
    int calcRunErr, nRuns, overlapCnt, copyErr, lpkCount, abortedCount;
    bit busyLog[2000];
    bit lpkLog[2000];
    bit abtLog[2000];

    task automatic doReset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic runPass(input bit holdStart, input int nCycles,
                           input int rstCycle, input int abortCycle);
        int  run;
        bit  prevIj;
        doneCycle = -1; doneCount = 0; wrCount = 0; wrOrderErr = 0;
        wrSpacingErr = 0; calcRunErr = 0; nRuns = 0; overlapCnt = 0;
        copyErr = 0; lpkCount = 0; abortedCount = 0;
        run = 0; prevIj = 1'b0;
        for (int c = 0; c < nCycles; c++) begin
            rst   = (c == rstCycle);
            start = (c == 0) || holdStart;
`ifdef COLPAR_CTRL_ABORT_EN
            abort = (c == abortCycle);
`endif
            @(negedge clk);
            busyLog[c] = busy;
            lpkLog[c]  = ldLinePK;
            abtLog[c]  = 1'b0;
`ifdef COLPAR_CTRL_ABORT_EN
            abtLog[c] = aborted;
            if (aborted) abortedCount++;
`endif
            if (sliceWrite) begin
                if (int'(sliceAddr) != wrCount) wrOrderErr++;
                if (c != 29 + 28 * wrCount) wrSpacingErr++;
                wrCount++;
            end
            if (sliceRead && sliceWrite) overlapCnt++;
            if (copyKtoPK != sliceWrite && c != abortCycle) copyErr++;
            if (calcEn) begin
                if (run == 0 && !prevIj) calcRunErr++;
                run++;
            end else if (run > 0) begin
                if (run != c_ELEMS) calcRunErr++;
                nRuns++;
                run = 0;
            end
            prevIj = colparIJrster;
            if (done) begin
                doneCount++;
                doneCycle = c;
            end
            if (ldLinePK) lpkCount++;
            @(posedge clk);
            #1;
        end
        rst   = 1'b0;
        start = 1'b0;
`ifdef COLPAR_CTRL_ABORT_EN
        abort = 1'b0;
`endif
    endtask

    initial begin
        logic [14:0] act;

        vecs[0] = '{1'b1, 1'b0, mk(0,0,0,0,0,0,0,0,0, 6'd0)};
        vecs[1] = '{1'b1, 1'b1, mk(0,0,0,0,0,0,0,0,0, 6'd0)};
        vecs[2] = '{1'b0, 1'b1, mk(0,0,0,0,0,0,0,0,0, 6'd0)};
        vecs[3] = '{1'b0, 1'b0, mk(1,0,1,0,0,1,0,0,0, 6'd63)};
        vecs[4] = '{1'b0, 1'b0, mk(1,0,1,0,1,0,0,0,0, 6'd0)};
        vecs[5] = '{1'b0, 1'b1, mk(1,0,0,0,0,0,0,1,0, 6'd0)};
        vecs[6] = '{1'b0, 1'b1, mk(1,0,0,0,0,0,0,0,1, 6'd0)};
        vecs[7] = '{1'b0, 1'b0, mk(1,0,0,0,0,0,0,0,1, 6'd0)};
        vecs[8] = '{1'b1, 1'b0, mk(0,0,0,0,0,0,0,0,0, 6'd0)};
        vecs[9] = '{1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0, 6'd0)};

        for (int i = 0; i < 10; i++) begin
            rst   = vecs[i].rst;
            start = vecs[i].start;
            @(negedge clk);
            act = {busy, done, sliceRead, sliceWrite, ldLineK, ldLinePK,
                   copyKtoPK, colparIJrster, calcEn, sliceAddr};
            nChecks++;
            if (act !== vecs[i].exp) begin
                nErrors++;
                $display("FAIL vec%0d: got %h, expected %h", i, act, vecs[i].exp);
            end
            @(posedge clk);
            #1;
        end
        rst   = 1'b0;
        start = 1'b0;

        // Full clean pass with a single-cycle start
        doReset();
        runPass(1'b0, c_DONE_CYC + 4, -1, -1);
        check("pass_done_cycle", doneCycle, c_DONE_CYC);
        check("pass_done_count", doneCount, 1);
        check("pass_busy_before_done", int'(busyLog[c_DONE_CYC - 1]), 1);
        check("pass_busy_after_done", int'(busyLog[c_DONE_CYC + 1]), 0);
        check("pass_write_count", wrCount, c_SLICES);
        check("pass_write_order", wrOrderErr, 0);
        check("pass_write_spacing", wrSpacingErr, 0);
        check("pass_calc_runs_err", calcRunErr, 0);
        check("pass_calc_runs", nRuns, c_SLICES);
        check("pass_rd_wr_overlap", overlapCnt, 0);
        check("pass_copy_with_write", copyErr, 0);
        check("pass_ldpk_count", lpkCount, 1);

        // Start held high throughout: restart only once back in IDLE
        doReset();
        runPass(1'b1, c_DONE_CYC + 4, -1, -1);
        check("hold_done_cycle", doneCycle, c_DONE_CYC);
        check("hold_write_count", wrCount, c_SLICES);
        check("hold_idle_gap", int'(busyLog[c_DONE_CYC + 1]), 0);
        check("hold_restart", int'(lpkLog[c_DONE_CYC + 2]), 1);
        check("hold_ldpk_count", lpkCount, 2);

        // Reset during CALC of slice 10 (CALC spans cycles 284..308)
        doReset();
        runPass(1'b0, 400, 290, -1);
        check("rst_write_count", wrCount, 10);
        check("rst_no_done", doneCount, 0);
        check("rst_busy_during", int'(busyLog[290]), 0);
        check("rst_busy_after", int'(busyLog[291]), 0);
        runPass(1'b0, c_DONE_CYC + 4, -1, -1);
        check("rst_repass_done", doneCycle, c_DONE_CYC);
        check("rst_repass_writes", wrCount, c_SLICES);
        check("rst_repass_order", wrOrderErr, 0);

`ifdef COLPAR_CTRL_ABORT_EN
        // Abort in WR of slice 5 (cycle 29 + 28*5)
        doReset();
        runPass(1'b0, 300, -1, 169);
        check("abort_write_count", wrCount, 5);
        check("abort_pulse_at", int'(abtLog[170]), 1);
        check("abort_pulse_count", abortedCount, 1);
        check("abort_busy_after", int'(busyLog[170]), 0);
        check("abort_no_done", doneCount, 0);
`endif

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/colpar_ctrl.md
COLPAR_CTRL -- requirements
Module: colpar_ctrl

Interface
REQ-001 The block SHALL have parameter SLICES, default 64, giving the number of 25-bit slices per state.
REQ-002 The block SHALL have parameter ELEMS, default 25, giving the number of column-parity element steps per slice.
REQ-003 The block SHALL have parameter AW, default 6, giving the slice address width (clog2 of SLICES).
REQ-004 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port start, input, 1: request one full theta pass; sampled only in IDLE.
REQ-007 Port sliceAddr, output, AW: slice memory address.
REQ-008 Port sliceRead, output, 1: slice memory read strobe; read data is combinational in the same cycle.
REQ-009 Port sliceWrite, output, 1: slice memory write strobe; the datapath newSlice is written to sliceAddr.
REQ-010 Port ldLineK, output, 1: load the read data into the lineKcp register.
REQ-011 Port ldLinePK, output, 1: load the read data into the linePKcp register.
REQ-012 Port copyKtoPK, output, 1: copy lineKcp into linePKcp, preserving original slice k before it is overwritten.
REQ-013 Port colparIJrster, output, 1: reset the datapath column-parity i/j/counter.
REQ-014 Port calcEn, output, 1: datapath element step active.
REQ-015 Port busy, output, 1: high in every state except IDLE.
REQ-016 Port done, output, 1: one-cycle pulse at completion.

Function
REQ-017 The FSM SHALL have states IDLE, RD_LAST, RD_CUR, INIT, CALC, WR and DONE, one-hot or binary-encoded.
REQ-018 IDLE SHALL go to RD_LAST when start=1 and stay in IDLE otherwise; start outside IDLE SHALL be ignored.
REQ-019 RD_LAST SHALL drive sliceAddr=SLICES-1, sliceRead=1 and ldLinePK=1, clear slice counter k to 0, and go to RD_CUR.
REQ-020 RD_CUR SHALL drive sliceAddr=k, sliceRead=1 and ldLineK=1, and go to INIT.
REQ-021 INIT SHALL drive colparIJrster=1, clear element counter e to 0, and go to CALC.
REQ-022 CALC SHALL drive calcEn=1 and increment e each cycle, lasting exactly ELEMS cycles (e=0..ELEMS-1), then go to WR.
REQ-023 WR SHALL drive sliceAddr=k, sliceWrite=1 and copyKtoPK=1; if k=SLICES-1 it SHALL go to DONE, else it SHALL increment k and go to RD_CUR.
REQ-024 DONE SHALL drive done=1 for exactly one cycle and go to IDLE.
REQ-025 All strobes SHALL be 0 outside the states named for them, and sliceAddr SHALL be 0 in IDLE, INIT, CALC and DONE.
REQ-026 sliceRead and sliceWrite SHALL never be high in the same cycle.
REQ-027 Per-slice latency SHALL be ELEMS+3 cycles (28 at defaults).
REQ-028 With start sampled high at edge 0, done SHALL be high in cycle 2+SLICES*(ELEMS+3) (1794 at defaults).
REQ-029 Slice 0 SHALL use original slice SLICES-1 as its previous slice.
REQ-030 Slice k>0 SHALL use original slice k-1, supplied via copyKtoPK and never from memory.
REQ-031 Counter k SHALL be AW bits wide and SHALL never wrap during a pass.
REQ-032 Counter e SHALL be 5 bits wide and saturate-free: it is cleared in INIT only.

Reset
REQ-033 While rst=1 at a clock edge, the next state SHALL be IDLE with k=0 and e=0.
REQ-034 During reset all outputs SHALL be 0, including busy and done.
REQ-035 rst SHALL take priority over start and abort.
REQ-036 rst asserted mid-pass SHALL abandon the pass with no further sliceWrite and no done pulse.

Configuration
REQ-037 When macro COLPAR_CTRL_ABORT_EN is defined, the block SHALL have an input port abort (1 bit) and an output port aborted (1 bit).
REQ-038 With COLPAR_CTRL_ABORT_EN defined, abort=1 in any state other than IDLE or DONE SHALL force IDLE at the next edge, suppress sliceWrite in that cycle, and pulse aborted for one cycle with no done pulse.
REQ-039 With COLPAR_CTRL_ABORT_EN defined, abort in IDLE or DONE SHALL be ignored.
REQ-040 When COLPAR_CTRL_ABORT_EN is undefined, the ports abort and aborted SHALL be absent and a pass SHALL always run to completion.

Verification
REQ-041 rst=1 for 2 cycles, then start=1 for 1 cycle -> busy=1 next cycle; sliceAddr=63 with sliceRead=1 and ldLinePK=1; then sliceAddr=0 with ldLineK=1.
REQ-042 Full pass at defaults -> exactly 64 sliceWrite pulses at addresses 0..63 in order; done high exactly in cycle 1794; busy low the cycle after.
REQ-043 Cycle count per slice -> 25 consecutive calcEn cycles, preceded by 1 colparIJrster cycle, with the WR cycles 28 cycles apart.
REQ-044 start held high through an entire pass -> no restart mid-pass; a new pass begins the cycle after DONE returns to IDLE.
REQ-045 rst=1 during CALC of slice 10 -> IDLE next cycle, no write to address 10, no done pulse; a subsequent start runs a full clean pass.
REQ-046 With COLPAR_CTRL_ABORT_EN defined, abort=1 in WR of slice 5 -> no sliceWrite that cycle, aborted=1 for one cycle, done stays 0, busy=0 the next cycle.
